// File: rtl/pulse_evt_pkg.sv
// rtl/pulse_evt_pkg.sv - shared types and constants for the pulse event arbiter
// Contents: cnt_state_t (modulo-4 pulse counter states), PEA_N_CH_DEF (default channel count).
package pulse_evt_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } cnt_state_t;

    localparam int PEA_N_CH_DEF = 4;

endpackage

// File: rtl/pulse_event_arbiter_if.sv
// rtl/pulse_event_arbiter_if.sv - valid/ready event channel toward the flag handler
// Signals: flag_valid (event presented), flag_ch (channel index), flag_ready (consumer accepts).
// Modports: master = event source (arbiter), slave = event consumer.
interface pulse_event_arbiter_if
    import pulse_evt_pkg::*;
#(
    parameter int N_CH = PEA_N_CH_DEF,
    parameter int CW   = $clog2(N_CH)
);
    logic          flag_valid;
    logic [CW-1:0] flag_ch;
    logic          flag_ready;

    modport master (output flag_valid, output flag_ch, input flag_ready);
    modport slave  (input flag_valid, input flag_ch, output flag_ready);
endinterface

// File: rtl/pulse_cnt4.sv
// rtl/pulse_cnt4.sv - modulo-4 pulse counter raising evt on every 4th pulse
// Ports: clk, rst (sync active-high), data (one pulse per cycle when 1),
//        evt (combinational: state S3 and data=1, i.e. the wrapping pulse).
module pulse_cnt4
    import pulse_evt_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic data,
    output logic evt
);
    cnt_state_t cnt_q;
    cnt_state_t cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= S0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (data) begin
            case (cnt_q)
                S0:      cnt_d = S1;
                S1:      cnt_d = S2;
                S2:      cnt_d = S3;
                default: cnt_d = S0;
            endcase
        end
    end

    always_comb begin
        evt = data && (cnt_q == S3);
    end
endmodule

// File: rtl/pulse_event_arbiter.sv
// rtl/pulse_event_arbiter.sv - per-channel pulse counters, one-deep event queue, round-robin flag output
// Ports: clk, rst (sync active-high), data[N_CH] (per-channel pulses), ovf_clr (clear overflow),
//        overflow[N_CH] (sticky drop indicator), flag_if (master: flag_valid/flag_ch out, flag_ready in).
module pulse_event_arbiter
    import pulse_evt_pkg::*;
#(
    parameter int N_CH = PEA_N_CH_DEF,
    parameter int CW   = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       data,
    input  logic                  ovf_clr,
    output logic [N_CH-1:0]       overflow,
    pulse_event_arbiter_if.master flag_if
);
    logic [N_CH-1:0] evt;

    logic [N_CH-1:0] pend_q, pend_d;
    logic [N_CH-1:0] overflow_q, overflow_d;
    logic            flag_valid_q, flag_valid_d;
    logic [CW-1:0]   flag_ch_q, flag_ch_d;
    logic [CW-1:0]   rr_ptr_q, rr_ptr_d;

    logic            slot_free;
    logic            load;
    logic            found;
    logic [CW-1:0]   win;
    logic [CW:0]     cand;
    logic [N_CH-1:0] loaded;
    logic [N_CH-1:0] drop;

    for (genvar g = 0; g < N_CH; g++) begin : g_cnt
        pulse_cnt4 u_cnt (
            .clk  (clk),
            .rst  (rst),
            .data (data[g]),
            .evt  (evt[g])
        );
    end

    // Round-robin search starting just after the last granted channel.
    // cand is one bit wider so the wrap works for non-power-of-two N_CH.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = {1'b0, rr_ptr_q} + (CW+1)'(k);
            if (cand >= (CW+1)'(N_CH)) begin
                cand = cand - (CW+1)'(N_CH);
            end
            if (!found && pend_q[cand[CW-1:0]]) begin
                found = 1'b1;
                win   = cand[CW-1:0];
            end
        end
    end

    always_comb begin
        slot_free    = !flag_valid_q || flag_if.flag_ready;
        load         = slot_free && found;
        loaded       = '0;
        drop         = '0;
        pend_d       = pend_q;
        for (int i = 0; i < N_CH; i++) begin
            loaded[i] = load && (win == CW'(i));
            // An event arriving as the channel is loaded refills the slot it just vacated.
            drop[i]   = evt[i] && pend_q[i] && !loaded[i];
            pend_d[i] = (pend_q[i] && !loaded[i]) || evt[i];
        end
        // Set beats clear when both happen in the same cycle.
        overflow_d   = (ovf_clr ? '0 : overflow_q) | drop;
        flag_valid_d = slot_free ? found : flag_valid_q;
        flag_ch_d    = load ? win : flag_ch_q;
        rr_ptr_d     = load ? win : rr_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q       <= '0;
            overflow_q   <= '0;
            flag_valid_q <= 1'b0;
            flag_ch_q    <= '0;
            rr_ptr_q     <= CW'(N_CH - 1);
        end else begin
            pend_q       <= pend_d;
            overflow_q   <= overflow_d;
            flag_valid_q <= flag_valid_d;
            flag_ch_q    <= flag_ch_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign overflow           = overflow_q;
    assign flag_if.flag_valid = flag_valid_q;
    assign flag_if.flag_ch    = flag_ch_q;
endmodule
